// File: rtl/l1_refill.sv
// L1 cache line refill engine: on a miss it requests the line from memory,
// assembles the returned beats, writes tag/data in one cycle and signals done.
module l1_refill #(
    parameter int WAY_NUM    = 4,
    parameter int IDX_W      = 7,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           miss_val,
    input  logic [ADDR_W-1:0]                              miss_addr,
    input  logic [WAY_NUM-1:0]                             miss_way_vect,
    input  logic                                           miss_evict,
    output logic                                           busy,
    output logic                                           mem_req,
    output logic [ADDR_W-1:0]                              mem_addr,
    input  logic                                           mem_ack,
    input  logic                                           mem_rvalid,
    input  logic [31:0]                                    mem_rdata,
    output logic                                           fill_we,
    output logic [IDX_W-1:0]                               fill_idx,
    output logic [WAY_NUM-1:0]                             fill_way_vect,
    output logic [ADDR_W-IDX_W-2-$clog2(LINE_WORDS)-1:0]   fill_tag,
    output logic [32*LINE_WORDS-1:0]                       fill_line,
    output logic                                           done,
    output logic [31:0]                                    done_word,
    output logic [15:0]                                    evict_cnt
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = 2 + BEAT_W;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DONE} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:2]              addr_q, addr_d;
    logic [WAY_NUM-1:0]             way_q, way_d;
    logic                           evict_q, evict_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [LINE_WORDS-1:0][31:0]    line_q, line_d;
    logic [15:0]                    evict_cnt_q, evict_cnt_d;
    logic                           rv_q;
    logic [31:0]                    rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            evict_q     <= 1'b0;
            beat_q      <= '0;
            line_q      <= '0;
            evict_cnt_q <= '0;
            rv_q        <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            evict_q     <= evict_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            evict_cnt_q <= evict_cnt_d;
            // Beats are registered before assembly; only those arriving in FILL count,
            // which also drops any beat coincident with mem_ack.
            rv_q        <= mem_rvalid && (state_q == FILL);
            rd_q        <= mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        evict_d     = evict_q;
        beat_d      = beat_q;
        line_d      = line_q;
        evict_cnt_d = evict_cnt_q;
        case (state_q)
            IDLE: begin
                if (miss_val) begin
                    addr_d  = miss_addr[ADDR_W-1:2];
                    way_d   = miss_way_vect;
                    evict_d = miss_evict;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (rv_q) begin
                    line_d[beat_q] = rd_q;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(LINE_WORDS-1))
                        state_d = WRITE;
                end
            end
            WRITE: begin
                if (evict_q && (evict_cnt_q != 16'hFFFF))
                    evict_cnt_d = evict_cnt_q + 16'd1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign mem_req       = (state_q == REQ);
    assign mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign fill_we       = (state_q == WRITE);
    assign fill_idx      = addr_q[OFF_W +: IDX_W];
    assign fill_tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign fill_way_vect = way_q;
    assign fill_line     = line_q;
    assign done          = (state_q == DONE);
    assign done_word     = line_q[addr_q[2 +: BEAT_W]];
    assign evict_cnt     = evict_cnt_q;
endmodule

// File: tb/tb_l1_refill.sv
// Directed bench for l1_refill: basic refill, ack wait/beat gaps, miss while busy,
// eviction counter with saturation, and reset during FILL.
module tb_l1_refill;
    logic         clk = 1'b0;
    logic         rst;
    logic         miss_val;
    logic [31:0]  miss_addr;
    logic [3:0]   miss_way_vect;
    logic         miss_evict;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         fill_we;
    logic [6:0]   fill_idx;
    logic [3:0]   fill_way_vect;
    logic [20:0]  fill_tag;
    logic [127:0] fill_line;
    logic         done;
    logic [31:0]  done_word;
    logic [15:0]  evict_cnt;

    l1_refill #(.WAY_NUM(4), .IDX_W(7), .ADDR_W(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .miss_val(miss_val), .miss_addr(miss_addr), .miss_way_vect(miss_way_vect),
        .miss_evict(miss_evict), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_way_vect(fill_way_vect),
        .fill_tag(fill_tag), .fill_line(fill_line),
        .done(done), .done_word(done_word), .evict_cnt(evict_cnt)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           n_we  = 0;
    int           n_done = 0;
    int           t_miss = 0;
    int           t_done = 0;
    logic [127:0] cap_line = '0;
    logic [6:0]   cap_idx  = '0;
    logic [20:0]  cap_tag  = '0;
    logic [3:0]   cap_way  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fill_we) begin
            n_we     <= n_we + 1;
            cap_line <= fill_line;
            cap_idx  <= fill_idx;
            cap_tag  <= fill_tag;
            cap_way  <= fill_way_vect;
        end
        if (done) begin
            n_done <= n_done + 1;
            t_done <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one refill. start=0 means the block is already in REQ at entry.
    task automatic refill(input logic [31:0] a, input logic [3:0] w, input logic ev,
                          input int ack_dly, input int gap,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic start, input logic hold, input logic [31:0] nxt);
        logic [31:0] ma;
        logic [31:0] dw;
        logic [31:0] d [4];
        int          we0;
        int          k;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        ma = {a[31:4], 4'h0};
        dw = d[a[3:2]];
        we0 = n_we;
        if (start) begin
            @(negedge clk);
            miss_val = 1'b1; miss_addr = a; miss_way_vect = w; miss_evict = ev;
            t_miss = cyc;
            @(negedge clk);
            if (hold) miss_addr = nxt;
            else      miss_val  = 1'b0;
        end
        chk("busy_req", busy, 1);
        for (int i = 0; i < ack_dly; i++) begin
            chk("req_wait", mem_req, 1);
            chk("addr_wait", mem_addr, ma);
            @(negedge clk);
        end
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, ma);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        chk("req_drop", mem_req, 0);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = d[i];
            @(negedge clk);
            mem_rvalid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
        chk("busy_on_done", busy, 1);
        chk("done_word", done_word, dw);
        chk("we_count", n_we - we0, 1);
        chk("fill_line", cap_line, {d3, d2, d1, d0});
        chk("fill_way", cap_way, w);
        @(negedge clk);
        chk("busy_after", busy, 0);
    endtask

    int we0;
    int dn0;

    initial begin
        rst = 1'b1; miss_val = 1'b0; miss_addr = '0; miss_way_vect = '0; miss_evict = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", fill_we, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dword", done_word, 0);
        chk("rst_line", fill_line, 0);
        chk("rst_idx", fill_idx, 0);
        chk("rst_tag", fill_tag, 0);
        chk("rst_way", fill_way_vect, 0);
        chk("rst_evict", evict_cnt, 0);
        rst = 1'b0;

        // Basic refill
        refill(32'h0000_1238, 4'b0100, 1'b0, 0, 0, 32'd11, 32'd22, 32'd33, 32'd44, 1'b1, 1'b0, '0);
        chk("b_idx", cap_idx, 7'h23);
        chk("b_tag", cap_tag, 21'h2);
        chk("b_line", cap_line, {32'd44, 32'd33, 32'd22, 32'd11});
        chk("b_latency", t_done - t_miss, 8);

        // Ack wait and beat gaps
        refill(32'h0000_1238, 4'b0001, 1'b0, 5, 1, 32'd11, 32'd22, 32'd33, 32'd44, 1'b1, 1'b0, '0);

        // Miss held while busy: second request must wait until after done
        refill(32'h0000_1238, 4'b1000, 1'b0, 0, 0, 32'd11, 32'd22, 32'd33, 32'd44,
               1'b1, 1'b1, 32'h0000_2004);
        chk("h_idx_first", cap_idx, 7'h23);
        chk("h_req_idle", mem_req, 0);
        @(negedge clk);
        chk("h_req2", mem_req, 1);
        chk("h_req2_gap", cyc - t_done, 2);
        miss_val = 1'b0;
        refill(32'h0000_2004, 4'b1000, 1'b0, 0, 0, 32'h55, 32'h66, 32'h77, 32'h88,
               1'b0, 1'b0, '0);
        chk("h_idx_second", cap_idx, 7'h00);
        chk("h_tag_second", cap_tag, 21'h4);

        // Evict counter
        refill(32'h0000_0010, 4'b0001, 1'b1, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b0, '0);
        chk("ev_1", evict_cnt, 1);
        refill(32'h0000_0020, 4'b0010, 1'b0, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b0, '0);
        chk("ev_2", evict_cnt, 1);
        refill(32'h0000_0030, 4'b0100, 1'b1, 1, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b0, '0);
        chk("ev_3", evict_cnt, 2);
        force dut.evict_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.evict_cnt_q;
        @(negedge clk);
        chk("ev_preload", evict_cnt, 16'hFFFE);
        refill(32'h0000_0040, 4'b0001, 1'b1, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b0, '0);
        chk("ev_max", evict_cnt, 16'hFFFF);
        refill(32'h0000_0050, 4'b0001, 1'b1, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b0, '0);
        chk("ev_sat", evict_cnt, 16'hFFFF);

        // Reset during FILL after two beats
        we0 = n_we; dn0 = n_done;
        @(negedge clk);
        miss_val = 1'b1; miss_addr = 32'h0000_3008; miss_way_vect = 4'b0010; miss_evict = 1'b1;
        @(negedge clk);
        miss_val = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA1;
        @(negedge clk);
        mem_rdata = 32'hA2;
        @(negedge clk);
        mem_rvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_busy", busy, 0);
        chk("r_evict", evict_cnt, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hA3;
        @(negedge clk);
        mem_rdata = 32'hA4;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (12) @(negedge clk);
        chk("r_no_we", n_we - we0, 0);
        chk("r_no_done", n_done - dn0, 0);
        chk("r_idle", busy, 0);
        refill(32'h0000_300C, 4'b0010, 1'b0, 0, 0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 1'b1, 1'b0, '0);
        chk("r_idx", cap_idx, 7'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/l1_refill.md
L1_REFILL -- requirements
Module: l1_refill

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  WAY_NUM 4: associativity; width of way vectors.
  IDX_W 7: set index width.
  ADDR_W 32: byte address width.
  LINE_WORDS 4: 32-bit words per line; power of two, at least 2.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  clk  in  1  clock; single clock domain.
  rst  in  1  reset; synchronous, active-high.
  miss_val  in  1  analyze-stage miss, i.e. request valid and no hit.
  miss_addr  in  ADDR_W  byte address of the missing access.
  miss_way_vect  in  WAY_NUM  one-hot victim way from the LRU stage.
  miss_evict  in  1  victim way holds a valid line.
  busy  out  1  refill in progress; pipeline stalls.
  mem_req  out  1  line-read request to memory.
  mem_addr  out  ADDR_W  line-aligned address.
  mem_ack  in  1  memory accepts the request.
  mem_rvalid  in  1  read data beat valid.
  mem_rdata  in  32  read data beat.
  fill_we  out  1  write strobe for the tag/valid and data arrays.
  fill_idx  out  IDX_W  set to write.
  fill_way_vect  out  WAY_NUM  way to write.
  fill_tag  out  ADDR_W-IDX_W-2-log2(LINE_WORDS)  tag to write.
  fill_line  out  32*LINE_WORDS  line data; word 0 in the LSBs.
  done  out  1  one-cycle pulse; refill complete.
  done_word  out  32  the originally missed word.
  evict_cnt  out  16  count of valid lines replaced.

Function
REQ-003 The state machine SHALL have exactly these states: IDLE, REQ, FILL, WRITE, DONE.
REQ-004 In IDLE, miss_val=1 SHALL latch the following, move to REQ, and assert busy on the next cycle:
  - miss_addr;
  - miss_way_vect;
  - miss_evict.
REQ-005 busy SHALL be 1 in every state other than IDLE; miss_val received outside IDLE SHALL be ignored.
REQ-006 In REQ, mem_req SHALL be 1, and mem_addr SHALL be the latched address with its low 2+log2(LINE_WORDS) bits forced to 0.
REQ-007 mem_req and mem_addr SHALL stay stable until the cycle in which mem_ack=1; the state SHALL then go to FILL on the next cycle.
REQ-008 mem_req SHALL be 0 in every state other than REQ.
REQ-009 In FILL, each mem_rvalid=1 cycle SHALL store mem_rdata into word slot beat_cnt and increment beat_cnt.
  - beat_cnt is a log2(LINE_WORDS)-bit counter, reset to 0 on entry to FILL.
  - Gaps with mem_rvalid=0 are legal.
REQ-010 The beat with beat_cnt=LINE_WORDS-1 SHALL move the state to WRITE; beat_cnt SHALL wrap to 0.
REQ-011 mem_rvalid outside FILL SHALL be ignored.
REQ-012 mem_rvalid in the same cycle as mem_ack SHALL be ignored, because the first beat is legal no earlier than one cycle after mem_ack.
REQ-013 In WRITE, fill_we SHALL be 1 for exactly one cycle, and the outputs SHALL carry these values:
  - fill_idx = latched address[IDX_W+2+log2(LINE_WORDS)-1 : 2+log2(LINE_WORDS)];
  - fill_tag = the remaining upper address bits;
  - fill_way_vect = the latched way vector;
  - fill_line = the assembled line.
  The state SHALL then go to DONE.
REQ-014 fill_we SHALL be 0 outside WRITE. Outside WRITE, fill_idx, fill_tag, fill_way_vect and fill_line are don't-care, but SHALL be free of X after reset.
REQ-015 In DONE, the outputs SHALL behave as follows, and the state SHALL go to IDLE:
  - done=1;
  - done_word = word slot address[2+log2(LINE_WORDS)-1:2] of the assembled line.
REQ-016 On its done cycle, busy SHALL still be 1; busy SHALL be 0 from the next cycle.
REQ-017 A new miss_val SHALL be accepted only in IDLE, so the earliest new acceptance is the cycle after done.
REQ-018 evict_cnt SHALL increment by 1 in the WRITE cycle if the latched miss_evict=1.
  - It SHALL saturate at 16'hFFFF.
  - It SHALL not wrap.
REQ-019 Minimum latency from miss_val in IDLE to done SHALL be LINE_WORDS+4 cycles. This assumes mem_ack arrives in the first REQ cycle and beats arrive back-to-back.
REQ-020 A miss_way_vect that is not one-hot is a caller error. The block SHALL pass it through to fill_way_vect unchanged, with no checking.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL take these reset values:
  - state = IDLE;
  - busy = 0, mem_req = 0, fill_we = 0, done = 0;
  - beat_cnt = 0;
  - evict_cnt = 0;
  - mem_addr, done_word, fill_line, fill_idx, fill_tag and fill_way_vect all zero.
REQ-022 rst asserted mid-refill, in any state, SHALL abandon the refill with no fill_we and no done. Memory beats still in flight after reset SHALL be ignored.
REQ-023 Reset SHALL be synchronous: rst asserted between clock edges SHALL have no effect until the next rising edge.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
  - Basic refill. Stimulus: LINE_WORDS=4; miss_val with addr 32'h0000_1238 and way 4'b0100; mem_ack immediate; beats 11,22,33,44 back-to-back. Required response: mem_addr=32'h0000_1230; fill_idx=7'h23, fill_way_vect=4'b0100, fill_line={44,33,22,11}; done_word=33; done exactly 8 cycles after miss_val.
  - Ack wait and beat gaps. Stimulus: mem_ack delayed 5 cycles; one idle cycle between each beat. Required response: mem_req/mem_addr stable for all 5 wait cycles; exactly one fill_we, with the same line as in the basic refill.
  - Miss while busy. Stimulus: miss_val held high throughout a refill. Required response: a second refill starts only in the IDLE cycle after done, with no overlap of mem_req.
  - Evict counter. Stimulus: 3 refills with miss_evict=1,0,1. Required response: evict_cnt=2. Then preload near saturation via a forced long run. Required response: evict_cnt holds at 16'hFFFF.
  - Reset in FILL. Stimulus: rst for 1 cycle after 2 beats, then the remaining beats arrive. Required response: no fill_we, no done, busy=0; the next refill completes correctly with beat_cnt starting at 0.
